divide: RTL

Iterative radix-2 integer divider execution unit for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the pipelined multiplier on the same integer issue port. It consumes the same `EX_UOp` issue format and produces `RES_UOp` results onto the writeback/result bus. Unlike the multiplier it is not pipelined: it holds one operation at a time and back-pressures issue through `OUT_busy`.

---
 rtl/divide.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/divide.sv
// rtl/divide.sv - iterative radix-2 RV32M DIV/DIVU/REM/REMU execution unit.
// Optional build macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass the iteration loop.

package divide_pkg;
    localparam int XLEN    = 32;
    localparam int TAG_W   = 7;
    localparam int SQN_W   = 7;
    localparam int FLAGS_W = 4;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_REM  = 2'd2,
        DIV_REMU = 2'd3
    } div_op_t;

    localparam logic [FLAGS_W-1:0] FLAGS_NONE = '0;

    typedef struct packed {
        logic             taken;
        logic [SQN_W-1:0] sqN;
    } BranchProv;

    typedef struct packed {
        logic             valid;
        div_op_t          opcode;
        logic [XLEN-1:0]  srcA;
        logic [XLEN-1:0]  srcB;
        logic [TAG_W-1:0] tagDst;
        logic [SQN_W-1:0] sqN;
    } EX_UOp;

    typedef struct packed {
        logic               valid;
        logic [TAG_W-1:0]   tagDst;
        logic [SQN_W-1:0]   sqN;
        logic [XLEN-1:0]    result;
        logic [FLAGS_W-1:0] flags;
        logic               doNotCommit;
    } RES_UOp;
endpackage

module divide
    import divide_pkg::*;
#(
    parameter int XLEN = divide_pkg::XLEN
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    output logic      OUT_busy,
    input  BranchProv IN_branch,
    input  EX_UOp     IN_uop,
    output RES_UOp    OUT_uop
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    RES_UOp             r_out;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_bmag;
    logic [XLEN-1:0]    r_a_raw;
    logic [CNT_W-1:0]   r_cnt;
    logic [TAG_W-1:0]   r_tag;
    logic [SQN_W-1:0]   r_sqn;
    logic               r_is_rem;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_div0;
    logic               r_ovf;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [SQN_W-1:0]   w_d_in;
    logic [SQN_W-1:0]   w_d_held;
    logic               w_flush_in;
    logic               w_flush_held;
    logic               w_accept;
    logic [XLEN:0]      w_trial;
    logic [XLEN-1:0]    w_q_fix;
    logic [XLEN-1:0]    w_r_fix;
    logic [XLEN-1:0]    w_result;

    // Sequence numbers wrap, so "younger than the branch" is a signed difference > 0.
    assign w_d_in       = IN_uop.sqN - IN_branch.sqN;
    assign w_d_held     = r_sqn - IN_branch.sqN;
    assign w_flush_in   = IN_branch.taken && !w_d_in[SQN_W-1] && (w_d_in != '0);
    assign w_flush_held = IN_branch.taken && !w_d_held[SQN_W-1] && (w_d_held != '0);

    assign w_signed = !IN_uop.opcode[0];
    assign w_a_neg  = w_signed && IN_uop.srcA[XLEN-1];
    assign w_b_neg  = w_signed && IN_uop.srcB[XLEN-1];
    assign w_accept = en && IN_uop.valid && (r_state == S_IDLE) && !w_flush_in;

    assign w_trial  = {r_rem, r_quo[XLEN-1]} - {1'b0, r_bmag};
    assign OUT_busy = (r_state != S_IDLE);
    assign OUT_uop  = r_out;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_LOAD;
            S_LOAD: begin
                w_next = S_ITER;
`ifdef DIV_FAST_SPECIAL_EN
                if (r_div0 || r_ovf) w_next = S_DONE;
`endif
                if (w_flush_held) w_next = S_IDLE;
            end
            S_ITER: begin
                if (r_cnt == '0) w_next = S_DONE;
                if (w_flush_held) w_next = S_IDLE;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Special cases override the loop result so both builds return identical values.
    always_comb begin
        w_q_fix = r_qneg ? -r_quo : r_quo;
        w_r_fix = r_rneg ? -r_rem : r_rem;
        if (r_div0) begin
            w_q_fix = '1;
            w_r_fix = r_a_raw;
        end else if (r_ovf) begin
            w_q_fix = {1'b1, {(XLEN-1){1'b0}}};
            w_r_fix = '0;
        end
        w_result = r_is_rem ? w_r_fix : w_q_fix;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag    <= IN_uop.tagDst;
            r_sqn    <= IN_uop.sqN;
            r_is_rem <= IN_uop.opcode[1];
            r_a_raw  <= IN_uop.srcA;
            r_quo    <= w_a_neg ? -IN_uop.srcA : IN_uop.srcA;
            r_bmag   <= w_b_neg ? -IN_uop.srcB : IN_uop.srcB;
            r_rem    <= '0;
            r_cnt    <= CNT_W'(XLEN - 1);
            r_qneg   <= w_a_neg ^ w_b_neg;
            r_rneg   <= w_a_neg;
            r_div0   <= (IN_uop.srcB == '0);
            r_ovf    <= w_signed && (IN_uop.srcA == {1'b1, {(XLEN-1){1'b0}}})
                        && (IN_uop.srcB == '1);
        end else if (r_state == S_ITER) begin
            r_cnt <= r_cnt - 1'b1;
            if (!w_trial[XLEN]) begin
                r_rem <= w_trial[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b1};
            end else begin
                r_rem <= {r_rem[XLEN-2:0], r_quo[XLEN-1]};
                r_quo <= {r_quo[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_out   <= '0;
        end else begin
            r_state     <= w_next;
            r_out.valid <= 1'b0;
            if (r_state == S_DONE && !w_flush_held) begin
                r_out.valid       <= 1'b1;
                r_out.tagDst      <= r_tag;
                r_out.sqN         <= r_sqn;
                r_out.result      <= w_result;
                r_out.flags       <= FLAGS_NONE;
                r_out.doNotCommit <= 1'b0;
            end
        end
    end
endmodule
